clk_divider: RTL and testbench

- Programmable clock divider (Taktteiler). Consumes the system clock and produces a divided, registered, glitch-free square wave `clk_out` plus a one-cycle period `tick`.
- The divisor is loaded through a valid/ready handshake and only changes at period boundaries.
- Sits downstream of the bench/system clock source and feeds slow-rate logic (blinkers, sampling strobes).

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_divider_if.sv | 25 ++
 rtl/clk_div_load.sv | 67 ++++++
 rtl/clk_divider.sv | 127 ++++++++++++
 tb/tb_clk_divider.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_divider block: FSM state encoding,
// the smallest legal divisor and the default counter width.
package clk_div_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int DIV_MIN   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/clk_divider_if.sv
// Control/status bundle of the clock divider: run request, divisor
// valid/ready slot, and the divided-clock outputs.
// The master side drives en and the divisor offer; the slave is the divider.
interface clk_divider_if #(
   parameter int CNT_W = clk_div_pkg::CNT_W_DEF
);
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_valid;
   logic             div_ready;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             err_div;

   modport master (
      output en, div_in, div_valid,
      input  div_ready, clk_out, tick, busy, err_div
   );

   modport slave (
      input  en, div_in, div_valid,
      output div_ready, clk_out, tick, busy, err_div
   );
endinterface

// File: rtl/clk_div_load.sv
// Divisor load slot: one-deep holding register behind a valid/ready
// handshake. Rejects divisors below DIV_MIN with a one-cycle err_div pulse,
// releases the held value when the counter says a change is allowed
// (idle or period wrap), and lets an offer that lands exactly in the wrap
// cycle go straight through without occupying the slot.
module clk_div_load
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             idle,
   input  logic             wrap,
   output logic             apply,
   output logic [CNT_W-1:0] apply_val,
   output logic             err_div
);

   logic             pending_reg, pending_next;
   logic [CNT_W-1:0] div_nxt_reg, div_nxt_next;
   logic             err_div_reg;
   logic             hs;
   logic             legal;

   assign div_ready = !pending_reg;
   assign hs        = div_valid && !pending_reg;
   assign legal     = (div_in >= CNT_W'(DIV_MIN));
   assign err_div   = err_div_reg;

   // Decide whether a divisor is handed to the counter this edge and update the slot.
   always_comb begin
      pending_next = pending_reg;
      div_nxt_next = div_nxt_reg;
      apply        = 1'b0;
      apply_val    = div_nxt_reg;
      if (pending_reg && (idle || wrap)) begin
         apply        = 1'b1;
         pending_next = 1'b0;
      end else if (hs && legal) begin
         if (wrap) begin
            apply     = 1'b1;
            apply_val = div_in;
         end else begin
            pending_next = 1'b1;
            div_nxt_next = div_in;
         end
      end
   end

   // Slot registers; err_div is a registered single-cycle pulse per rejected offer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= 1'b0;
         div_nxt_reg <= '0;
         err_div_reg <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         div_nxt_reg <= div_nxt_next;
         err_div_reg <= hs && !legal;
      end
   end

endmodule

// File: rtl/clk_divider.sv
// Programmable clock divider. Produces a registered square wave clk_out
// (high for ceil(N/2) of every N cycles) and a tick in the last cycle of
// each period. Stopping always finishes the running period first.
// Optional feature macro: CLK_DIVIDER_PERIOD_CNT_EN adds a saturating
// 32-bit count of completed periods on port period_cnt.
module clk_divider
   import clk_div_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DIV_RESET = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   clk_divider_if.slave bus
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
   ,
   output logic [31:0]  period_cnt
`endif
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] div_cur_reg, div_cur_next;
   logic             clk_out_reg, clk_out_next;
   logic             tick_reg, tick_next;
   logic             busy_reg, busy_next;
   logic [CNT_W:0]   half_next;
   logic             idle;
   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] apply_val;
   logic             div_ready;
   logic             err_div;

   assign idle = (state_reg == IDLE);
   assign wrap = !idle && (cnt_reg == div_cur_reg - CNT_W'(1));

   clk_div_load #(
      .CNT_W (CNT_W)
   ) u_load (
      .clk       (clk),
      .rst_n     (rst_n),
      .div_in    (bus.div_in),
      .div_valid (bus.div_valid),
      .div_ready (div_ready),
      .idle      (idle),
      .wrap      (wrap),
      .apply     (apply),
      .apply_val (apply_val),
      .err_div   (err_div)
   );

   // Next state/count, and the outputs that the next count will produce.
   // en is only honoured at period boundaries: a drop mid-period parks in
   // DRAIN, a drop seen on the wrap cycle itself stops right there.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      div_cur_next = apply ? apply_val : div_cur_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (bus.en) begin
               state_next = RUN;
            end
         end
         RUN, DRAIN: begin
            if (wrap) begin
               cnt_next   = '0;
               state_next = bus.en ? RUN : IDLE;
            end else begin
               cnt_next   = cnt_reg + CNT_W'(1);
               state_next = bus.en ? RUN : DRAIN;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      busy_next    = (state_next != IDLE);
      half_next    = ({1'b0, div_cur_next} + (CNT_W+1)'(1)) >> 1;
      clk_out_next = busy_next && ({1'b0, cnt_next} < half_next);
      tick_next    = busy_next && (cnt_next == div_cur_next - CNT_W'(1));
   end

   // State, counter, active divisor and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         div_cur_reg <= CNT_W'(DIV_RESET);
         clk_out_reg <= 1'b0;
         tick_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         div_cur_reg <= div_cur_next;
         clk_out_reg <= clk_out_next;
         tick_reg    <= tick_next;
         busy_reg    <= busy_next;
      end
   end

   assign bus.clk_out   = clk_out_reg;
   assign bus.tick      = tick_reg;
   assign bus.busy      = busy_reg;
   assign bus.div_ready = div_ready;
   assign bus.err_div   = err_div;

`ifdef CLK_DIVIDER_PERIOD_CNT_EN
   logic [31:0] period_cnt_reg;

   // Completed-period counter; survives IDLE, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt_reg <= '0;
      end else if (tick_reg && (period_cnt_reg != 32'hFFFF_FFFF)) begin
         period_cnt_reg <= period_cnt_reg + 32'd1;
      end
   end

   assign period_cnt = period_cnt_reg;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider. A behavioural model tracks the
// position inside the current period, the active divisor and the one-deep
// divisor slot; outputs are derived from that position with plain arithmetic.
module tb_clk_divider;

   localparam int CNT_W     = 16;
   localparam int DIV_RESET = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   clk_divider_if #(.CNT_W(CNT_W)) bus();

`ifdef CLK_DIVIDER_PERIOD_CNT_EN
   logic [31:0] period_cnt;
`endif

   clk_divider #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   int passed = 0;
   int total  = 0;

   // ---------------- reference model ----------------
   bit          m_active;
   int          m_pos;
   int          m_N;
   bit          m_pend;
   int          m_pend_val;
   bit          m_err;
   logic [31:0] m_periods;
   bit          m_eop, m_hs, m_ok;

   assign m_eop = m_active && (m_pos == m_N - 1);
   assign m_hs  = bus.div_valid && !m_pend;
   assign m_ok  = (int'(bus.div_in) >= 2);

   // Running means "inside a period"; a stop request only takes effect when a period ends.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active   <= 1'b0;
         m_pos      <= 0;
         m_N        <= DIV_RESET;
         m_pend     <= 1'b0;
         m_pend_val <= 0;
         m_err      <= 1'b0;
         m_periods  <= '0;
      end else begin
         m_err <= m_hs && !m_ok;
         if (m_eop && (m_periods != 32'hFFFF_FFFF)) m_periods <= m_periods + 32'd1;
         if (m_pend && (!m_active || m_eop)) begin
            m_N    <= m_pend_val;
            m_pend <= 1'b0;
         end else if (m_hs && m_ok) begin
            if (m_eop) m_N <= int'(bus.div_in);
            else begin
               m_pend     <= 1'b1;
               m_pend_val <= int'(bus.div_in);
            end
         end
         if (!m_active || m_eop) begin
            m_active <= bus.en;
            m_pos    <= 0;
         end else begin
            m_pos <= m_pos + 1;
         end
      end
   end

   logic [4:0] exp_vec, obs_vec;
   assign exp_vec = {m_active && (m_pos < (m_N + 1) / 2), m_active && (m_pos == m_N - 1),
                     m_active, !m_pend, m_err};
   assign obs_vec = {bus.clk_out, bus.tick, bus.busy, bus.div_ready, bus.err_div};

   // Stimulus helper: offer a divisor for one cycle while idle and let it settle.
   task automatic load_idle(input int v);
      bus.div_valid = 1'b1;
      bus.div_in    = 16'(v);
      @(posedge clk); #1;
      bus.div_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      bus.en = 1'b0; bus.div_valid = 1'b0; bus.div_in = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs_vec !== 5'b00010) $display("FAIL reset_state got=%b exp=%b", obs_vec, 5'b00010);
      else passed++;
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 32'd0) $display("FAIL reset_period_cnt got=%0d exp=0", period_cnt);
      else passed++;
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (obs_vec !== exp_vec) $display("FAIL reset_release got=%b exp=%b", obs_vec, exp_vec);
      else passed++;
      $display("reset: done");
   endtask

   task automatic test_n10;
      int highs = 0;
      int first_tick = -1;
      bus.en = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL n10 cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
         if (c == 1) begin
            total++;
            if (bus.clk_out !== 1'b1) $display("FAIL n10_latency got=%b exp=1", bus.clk_out);
            else passed++;
         end
         if (c <= 10 && bus.clk_out === 1'b1) highs++;
         if (first_tick < 0 && bus.tick === 1'b1) first_tick = c;
      end
      total++;
      if (highs != 5) $display("FAIL n10_high_cycles got=%0d exp=5", highs);
      else passed++;
      total++;
      if (first_tick != 10) $display("FAIL n10_first_tick got=%0d exp=10", first_tick);
      else passed++;
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL n10_drain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      total++;
      if (bus.busy !== 1'b0) $display("FAIL n10_stop got=%b exp=0", bus.busy);
      else passed++;
      $display("n10: highs=%0d first_tick=%0d", highs, first_tick);
   endtask

   task automatic test_idle_load;
      int highs = 0;
      int ticks = 0;
      bus.div_valid = 1'b1;
      bus.div_in    = 16'd7;
      @(posedge clk); #1;
      bus.div_valid = 1'b0;
      total++;
      if (obs_vec !== exp_vec) $display("FAIL idle_load_capture got=%b exp=%b", obs_vec, exp_vec);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (bus.div_ready !== 1'b1) $display("FAIL idle_load_apply got=%b exp=1", bus.div_ready);
      else passed++;
      bus.en = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL n7 cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
         if (c <= 7 && bus.clk_out === 1'b1) highs++;
         if (bus.tick === 1'b1) ticks++;
      end
      total++;
      if (highs != 4 || ticks != 3) $display("FAIL n7_shape got=%0d/%0d exp=4/3", highs, ticks);
      else passed++;
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL n7_drain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      $display("idle_load: highs=%0d ticks=%0d", highs, ticks);
   endtask

   task automatic test_mid_load;
      int wait_c = int'($urandom_range(2, 6));
      load_idle(10);
      bus.en = 1'b1;
      for (int c = 0; c < wait_c; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL mid_pre cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      bus.div_valid = 1'b1;
      bus.div_in    = 16'd4;
      @(posedge clk); #1;
      bus.div_valid = 1'b0;
      total++;
      if (bus.div_ready !== 1'b0) $display("FAIL mid_ready_low got=%b exp=0", bus.div_ready);
      else passed++;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL mid_load cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL mid_drain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      $display("mid_load: offered N=4 after %0d cycles", wait_c);
   endtask

   task automatic test_illegal;
      int errs = 0;
      bus.en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         bus.div_valid = (c == 2 || c == 5);
         bus.div_in    = (c == 2) ? 16'd1 : 16'd0;
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL illegal cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
         if (bus.err_div === 1'b1) errs++;
      end
      bus.div_valid = 1'b0;
      total++;
      if (errs != 2) $display("FAIL illegal_err_count got=%0d exp=2", errs);
      else passed++;
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL illegal_drain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      $display("illegal: err pulses=%0d", errs);
   endtask

   task automatic test_drain;
      int drain_c = 0;
      int gaps = 0;
      load_idle(10);
      bus.en = 1'b1;
      for (int c = 0; c < 20 && !(m_active && m_pos == 3); c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL drain_pre cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      bus.en = 1'b0;
      for (int c = 0; c < 20 && m_active; c++) begin
         @(posedge clk); #1;
         drain_c++;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL drain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      total++;
      if ({bus.busy, bus.clk_out} !== 2'b00 || drain_c != 7)
         $display("FAIL drain_stop got=busy%b/clk%b/%0d exp=busy0/clk0/7", bus.busy, bus.clk_out, drain_c);
      else passed++;
      bus.en = 1'b1;
      for (int c = 0; c < 20 && !(m_active && m_pos == 3); c++) begin
         @(posedge clk); #1;
      end
      bus.en = 1'b0;
      for (int c = 0; c < 20 && !(m_active && m_pos == 6); c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL redrain cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
      bus.en = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL rerun cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
         if (bus.busy !== 1'b1) gaps++;
      end
      total++;
      if (gaps != 0) $display("FAIL rerun_gap got=%0d exp=0", gaps);
      else passed++;
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
      end
      $display("drain: drain_cycles=%0d gaps=%0d", drain_c, gaps);
   endtask

   task automatic test_random;
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         end else passed++;
         bus.div_valid = ($urandom_range(0, 7) == 0);
         bus.div_in    = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 15) == 0) bus.en = !bus.en;
      end
      bus.div_valid = 1'b0;
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
      end
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
      total++;
      if (period_cnt !== m_periods) $display("FAIL random_period_cnt got=%0d exp=%0d", period_cnt, m_periods);
      else passed++;
`endif
      $display("random: 600 cycles, mismatching=%0d", bad);
   endtask

   task automatic test_async_reset;
      load_idle(10);
      bus.en = 1'b1;
      for (int c = 0; c < 20 && !(m_active && m_pos == 1); c++) begin
         @(posedge clk); #1;
      end
      bus.div_valid = 1'b1;
      bus.div_in    = 16'd6;
      @(posedge clk); #1;
      bus.div_valid = 1'b0;
      total++;
      if (bus.div_ready !== 1'b0) $display("FAIL areset_pending got=%b exp=0", bus.div_ready);
      else passed++;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs_vec !== 5'b00010) $display("FAIL areset_immediate got=%b exp=%b", obs_vec, 5'b00010);
      else passed++;
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 32'd0) $display("FAIL areset_period_cnt got=%0d exp=0", period_cnt);
      else passed++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(posedge clk); #1;
         total++;
         if (obs_vec !== exp_vec) $display("FAIL areset_run cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
         else passed++;
      end
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 32'd3) $display("FAIL areset_three_ticks got=%0d exp=3", period_cnt);
      else passed++;
`endif
      bus.en = 1'b0;
      for (int c = 0; c < 40 && m_active; c++) begin
         @(posedge clk); #1;
      end
      $display("async_reset: done");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_n10();
      test_idle_load();
      test_mid_load();
      test_illegal();
      test_drain();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
